int_div_unit: RTL
=================

INT_DIV_UNIT -- requirements
Module: int_div_unit

Interface
REQ-001 SHALL have ports: clk, input, 1, clock, rising edge.
REQ-002 SHALL have ports: reset, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports: p_start, input, 1, operands valid pulse from the EXE-stage start vector (divider bit).
REQ-004 SHALL have ports: div_op, input, div_op_t (2), DIV=00, DIVU=01, REM=10, REMU=11.
REQ-005 SHALL have ports: rs1_data, input, 32, dividend.
REQ-006 SHALL have ports: rs2_data, input, 32, divisor.
REQ-007 SHALL have ports: kill, input, 1, pipeline flush; aborts the in-flight operation.
REQ-008 SHALL have ports: stall, input, 1, result not accepted by the priority controller this cycle.
REQ-009 SHALL have ports: result, output, 32, quotient or remainder.
REQ-010 SHALL have ports: p_last, output, 1, result valid; this unit's bit of the "last" vector.
REQ-011 SHALL have ports: busy, output, 1, drives div_unit_busy.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE (or in DONE with stall low) with p_start high, latch the operands and the operation; cycle 0 is the start cycle.
REQ-014 SHALL use restoring radix-2 division on absolute values for signed ops, with a 6-bit counter and one quotient bit per CALC cycle.
REQ-015 SHALL, for a normal operation, be in CALC for cycles 1..32 and in DONE with p_last high in cycle 33.
REQ-016 SHALL apply sign correction on the CALC->DONE edge: quotient negated if operand signs differ; remainder takes the sign of the dividend.
REQ-017 SHALL, when the divisor is 0, go directly to DONE in cycle 1 with quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-018 SHALL, for signed overflow (0x80000000 / 0xFFFFFFFF), go directly to DONE in cycle 1 with quotient 0x80000000 and remainder 0.
REQ-019 SHALL select result as the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-020 SHALL, in DONE with stall high, hold result and p_last unchanged.
REQ-021 SHALL, in DONE with stall low, leave DONE next cycle: to CALC if p_start is high, otherwise to IDLE.
REQ-022 SHALL drive busy high only in CALC, and drive p_last high only in DONE.
REQ-023 SHALL ignore p_start while in CALC, and flag it as a protocol error by assertion.
REQ-024 SHALL, on kill in any state, enter IDLE on the next cycle with no p_last; kill has priority over p_start in the same cycle.
REQ-025 SHALL hold result stable outside DONE; its value there is don't-care.

Reset
REQ-026 SHALL, on reset asserted, asynchronously force state to IDLE and busy, p_last, result, counter and all operand registers to 0.
REQ-027 SHALL abort any in-flight operation on reset mid-operation with no p_last; the first start after release behaves normally.

Structure
REQ-028 SHALL define div_op_t and the constant DIV_ITER=32 in the shared riscv_types package.
REQ-029 SHALL keep the FSM state enum local to the module.
REQ-030 SHALL be a flat module with no sub-module; the iteration step is inline combinational logic.

Verification
REQ-031 SHALL cover: DIV 100/7 -> result 14; busy high cycles 1-32; p_last high cycle 33 only.
REQ-032 SHALL cover: REM -100/7 -> 0xFFFFFFFE (-2); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF/2 -> 1.
REQ-033 SHALL cover: DIV 5/0 -> 0xFFFFFFFF at cycle 1, busy never high; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
REQ-034 SHALL cover: kill at cycle 10 -> busy low at cycle 11, no p_last; a new DIV 9/3 -> 3 at its own cycle 33.
REQ-035 SHALL cover: stall high 3 cycles in DONE -> result/p_last held 3 cycles; p_start with stall low -> back-to-back op, correct second result.
REQ-036 SHALL cover: reset pulse at cycle 20 -> all outputs 0 immediately; a following DIVU 50/5 -> 10 at cycle 33.

Source files
------------

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V execution-unit types: divider operation encoding and iteration count.
// The helpers classify an operation as signed and/or remainder-producing.
package riscv_types;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   localparam int DIV_ITER = 32;

   function automatic logic is_signed_op(input div_op_t op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_rem_op(input div_op_t op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/int_div_unit.sv
// Iterative 32-bit integer divider: restoring radix-2 on magnitudes, one quotient bit per cycle.
// Handshake: p_start is accepted in IDLE, or in DONE with stall low; p_last marks DONE, held while stall is high.
module int_div_unit
   import riscv_types::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        p_start,
   input  div_op_t     div_op,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        kill,
   input  logic        stall,
   output logic [31:0] result,
   output logic        p_last,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] LAST_CNT = 6'(DIV_ITER - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dsr_q, dsr_d;
   logic [31:0] result_q, result_d;
   div_op_t     op_q, op_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;

   logic        in_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic        div_zero, sgn_ovf;
   logic        launch;

   logic [32:0] shifted;
   logic [33:0] trial;
   logic        q_bit;
   logic [31:0] quo_nx, rem_nx;
   logic [31:0] quo_fix, rem_fix, final_res;
   logic        unused_trial_bit;

   assign in_signed = is_signed_op(div_op);
   assign a_neg     = in_signed & rs1_data[31];
   assign b_neg     = in_signed & rs2_data[31];
   assign a_abs     = a_neg ? (~rs1_data + 32'd1) : rs1_data;
   assign b_abs     = b_neg ? (~rs2_data + 32'd1) : rs2_data;
   assign div_zero  = (rs2_data == 32'd0);
   assign sgn_ovf   = in_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);

   assign launch = p_start && !kill &&
                   ((state_q == IDLE) || ((state_q == DONE) && !stall));

   // quo_q starts as the dividend magnitude and shifts out its MSB while quotient bits shift in
   assign shifted          = {rem_q, quo_q[31]};
   assign trial            = {1'b0, shifted} - {2'b00, dsr_q};
   assign q_bit            = ~trial[33];
   assign rem_nx           = q_bit ? trial[31:0] : shifted[31:0];
   assign quo_nx           = {quo_q[30:0], q_bit};
   assign unused_trial_bit = trial[32];

   assign quo_fix   = q_neg_q ? (~quo_nx + 32'd1) : quo_nx;
   assign rem_fix   = r_neg_q ? (~rem_nx + 32'd1) : rem_nx;
   assign final_res = is_rem_op(op_q) ? rem_fix : quo_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      result_d = result_q;
      op_d     = op_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;

      if (kill) begin
         state_d = IDLE;
      end else if (launch) begin
         op_d    = div_op;
         q_neg_d = a_neg ^ b_neg;
         r_neg_d = a_neg;
         quo_d   = a_abs;
         rem_d   = '0;
         dsr_d   = b_abs;
         cnt_d   = '0;
         // divide-by-zero and signed overflow bypass the iteration entirely
         if (div_zero) begin
            state_d  = DONE;
            result_d = is_rem_op(div_op) ? rs1_data : 32'hFFFF_FFFF;
         end else if (sgn_ovf) begin
            state_d  = DONE;
            result_d = is_rem_op(div_op) ? 32'd0 : 32'h8000_0000;
         end else begin
            state_d = CALC;
         end
      end else begin
         case (state_q)
            CALC: begin
               cnt_d = cnt_q + 6'd1;
               quo_d = quo_nx;
               rem_d = rem_nx;
               if (cnt_q == LAST_CNT) begin
                  state_d  = DONE;
                  result_d = final_res;
               end
            end
            DONE: begin
               if (!stall) state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         result_q <= '0;
         op_q     <= DIV;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dsr_q    <= dsr_d;
         result_q <= result_d;
         op_q     <= op_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
      end
   end

   assign result = result_q;
   assign p_last = (state_q == DONE);
   assign busy   = (state_q == CALC);

   // a new start while iterating is dropped by the FSM; it indicates an upstream protocol bug
   p_start_in_calc: assert property (@(posedge clk) disable iff (reset)
                                     !((state_q == CALC) && p_start));

endmodule
